// File: rtl/tilt_pkg.sv
// Shared definitions for the tilt decoder.
//   tilt_state_t      : sequencing FSM states (ACCUM is the reset state)
//   TILT_LEVEL        : offset-binary code of a level axis; also the neutral threshold
//   TILT_NEUTRAL_DIR  : {increment, decrement} value that commands no movement
package tilt_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    COMPUTE = 2'd1,
    PUBLISH = 2'd2
  } tilt_state_t;

  localparam logic [7:0] TILT_LEVEL       = 8'd128;
  localparam logic [1:0] TILT_NEUTRAL_DIR = 2'b00;

endpackage

// File: rtl/tilt_axis_filter.sv
// One axis of the tilt decoder: accumulates accepted samples, averages the
// window with a truncating shift, and classifies the average against a
// dead band centred on TILT_LEVEL.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   sample       : raw 8-bit offset-binary sample
//   accept       : add sample into the running sum this cycle
//   clear        : empty the running sum (wins over accept)
//   load         : register the average and direction bits
//   neutral      : force direction bits neutral and threshold to level (wins over load)
//   increment    : average above the dead band
//   decrement    : average below the dead band
//   threshold    : last published average
module tilt_axis_filter
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int DEADBAND = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic       accept,
  input  logic       clear,
  input  logic       load,
  input  logic       neutral,
  output logic       increment,
  output logic       decrement,
  output logic [7:0] threshold
);

  localparam int SW = 8 + AVG_LOG2;
  // Nine bits so 128+DEADBAND (up to 255) compares without wrap.
  localparam logic [8:0] HI_LIMIT = 9'(128 + DEADBAND);
  localparam logic [8:0] LO_LIMIT = 9'(128 - DEADBAND);

  logic [SW-1:0] sum;
  logic [7:0]    avg;
  logic [1:0]    dir_next;  // {increment, decrement}
  logic [1:0]    dir;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum + SW'(sample);
    end
  end

  // sum >> AVG_LOG2; the top 8 bits are exactly the truncated mean.
  assign avg = sum[SW-1 -: 8];

  // Strict comparisons: an average equal to a band edge stays neutral,
  // and the two branches make both bits set impossible.
  always_comb begin
    dir_next = TILT_NEUTRAL_DIR;
    if ({1'b0, avg} > HI_LIMIT) begin
      dir_next = 2'b10;
    end else if ({1'b0, avg} < LO_LIMIT) begin
      dir_next = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir       <= TILT_NEUTRAL_DIR;
      threshold <= TILT_LEVEL;
    end else if (neutral) begin
      dir       <= TILT_NEUTRAL_DIR;
      threshold <= TILT_LEVEL;
    end else if (load) begin
      dir       <= dir_next;
      threshold <= avg;
    end
  end

  assign increment = dir[1];
  assign decrement = dir[0];

endmodule

// File: rtl/tilt_decoder.sv
// Tilt decoder top: averages 2^AVG_LOG2 accelerometer samples per axis and
// publishes dead-band direction commands plus the averaged codes.
// Optional stale watchdog compiled in with `define TILT_STALE_TIMEOUT_EN.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   accel_x, accel_y      : raw samples, offset-binary (128 = level)
//   sample_valid          : samples on accel_x/accel_y are valid
//   sample_ready          : block accepts a sample this cycle
//   x/y_increment/decrement : direction commands
//   x/y_threshold         : averaged tilt codes
//   out_valid             : one-cycle pulse when outputs update
//   stale                 : no fresh samples, outputs neutral
// Handshake: a sample is taken on every cycle where sample_valid and
// sample_ready are both 1; sample_ready never depends on sample_valid.
// FSM state is the internal signal 'state' (tilt_state_t) for checkers.
module tilt_decoder
  import tilt_pkg::*;
#(
  parameter int AVG_LOG2       = 2,
  parameter int DEADBAND       = 8,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] accel_x,
  input  logic [7:0] accel_y,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       x_increment,
  output logic       x_decrement,
  output logic       y_increment,
  output logic       y_decrement,
  output logic [7:0] x_threshold,
  output logic [7:0] y_threshold,
  output logic       out_valid,
  output logic       stale
);

  // One spare bit so the count can reach 2^AVG_LOG2 (also covers AVG_LOG2=0).
  localparam int             CW   = AVG_LOG2 + 1;
  localparam logic [CW-1:0]  LAST = CW'((1 << AVG_LOG2) - 1);

  tilt_state_t   state;
  tilt_state_t   state_next;
  logic [CW-1:0] count;
  logic          ready_en;   // low in reset, high from the first edge after release
  logic          accept;
  logic          timeout;
  logic          clear_acc;
  logic          load_out;

  assign sample_ready = ready_en && (state == ACCUM);
  assign accept       = sample_valid && sample_ready;
  assign out_valid    = (state == PUBLISH);
  // Leaving PUBLISH re-enters ACCUM, so that is where the window empties.
  assign clear_acc    = timeout || (state == PUBLISH);
  assign load_out     = (state == COMPUTE) && !timeout;

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && (count == LAST)) state_next = COMPUTE;
      COMPUTE: state_next = PUBLISH;
      PUBLISH: state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
    if (timeout) state_next = ACCUM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ACCUM;
      ready_en <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (clear_acc) begin
        count <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
      end
    end
  end

`ifdef TILT_STALE_TIMEOUT_EN
  localparam int WW = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WW-1:0] wd_cnt;
  logic          stale_q;

  assign timeout = (wd_cnt == WW'(TIMEOUT_CYCLES));
  assign stale   = stale_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      stale_q <= 1'b0;
    end else begin
      if (accept || timeout) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      // Cleared on the edge into PUBLISH so the fresh publish is not stale.
      if (timeout) begin
        stale_q <= 1'b1;
      end else if (state == COMPUTE) begin
        stale_q <= 1'b0;
      end
    end
  end
`else
  // Watchdog compiled out: timeout is constant false (TIMEOUT_CYCLES is
  // never negative), stale is tied low.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign stale   = 1'b0;
`endif

  tilt_axis_filter #(.AVG_LOG2(AVG_LOG2), .DEADBAND(DEADBAND)) u_x_filter (
    .clk       (clk),
    .reset     (reset),
    .sample    (accel_x),
    .accept    (accept),
    .clear     (clear_acc),
    .load      (load_out),
    .neutral   (timeout),
    .increment (x_increment),
    .decrement (x_decrement),
    .threshold (x_threshold)
  );

  tilt_axis_filter #(.AVG_LOG2(AVG_LOG2), .DEADBAND(DEADBAND)) u_y_filter (
    .clk       (clk),
    .reset     (reset),
    .sample    (accel_y),
    .accept    (accept),
    .clear     (clear_acc),
    .load      (load_out),
    .neutral   (timeout),
    .increment (y_increment),
    .decrement (y_decrement),
    .threshold (y_threshold)
  );

endmodule

// File: tb/tb_tilt_decoder.sv
// Bench for tilt_decoder: directed windows with hand-computed results,
// scoreboard queue filled by the driver, drained by a negedge monitor.
// Expected word: {x_inc, x_dec, y_inc, y_dec, x_threshold, y_threshold}.
module tb_tilt_decoder;

  localparam int W = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] accel_x = 8'd0;
  logic [7:0] accel_y = 8'd0;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       x_increment, x_decrement, y_increment, y_decrement;
  logic [7:0] x_threshold, y_threshold;
  logic       out_valid;
  logic       stale;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int cycle = 0;
  int acc_in_win = 0;
  int last_acc_cycle = -100;
  int ready_low_run = 0;
  bit ready_seen = 1'b0;
  bit cont_mode = 1'b0;
  int prev_pub = -1;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  tilt_decoder #(
    .AVG_LOG2       (2),
    .DEADBAND       (8),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .x_increment  (x_increment),
    .x_decrement  (x_decrement),
    .y_increment  (y_increment),
    .y_decrement  (y_decrement),
    .x_threshold  (x_threshold),
    .y_threshold  (y_threshold),
    .out_valid    (out_valid),
    .stale        (stale)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n;
    sample_valid = 1'b1;
    accel_x = x;
    accel_y = y;
    n = 0;
    @(negedge clk);
    while (!sample_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) chk("ready_wait_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  // xs/ys hold four samples, first sample in the top byte.
  task automatic window(input logic [31:0] xs, input logic [31:0] ys, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    for (int i = 3; i >= 0; i--) begin
      send(xs[i*8 +: 8], ys[i*8 +: 8]);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_neutral(input string tag);
    chk({tag, "_dirs"}, {28'd0, x_increment, x_decrement, y_increment, y_decrement}, 32'd0);
    chk({tag, "_x_threshold"}, {24'd0, x_threshold}, 32'd128);
    chk({tag, "_y_threshold"}, {24'd0, y_threshold}, 32'd128);
    chk({tag, "_stale"}, {31'd0, stale}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (!reset) begin
      acc_in_win = 0;
      ready_low_run = 0;
      ready_seen = 1'b0;
      prev_pub = -1;
    end else begin
      if (sample_valid && sample_ready) begin
        acc_in_win++;
        last_acc_cycle = cycle;
      end
      if (sample_ready) begin
        if (ready_seen && ready_low_run > 0) chk("ready_low_cycles", 32'(ready_low_run), 32'd2);
        ready_low_run = 0;
        ready_seen = 1'b1;
      end else if (ready_seen) begin
        ready_low_run++;
      end
      if (out_valid) begin
        chk("accepts_per_window", 32'(acc_in_win), 32'd4);
        acc_in_win = 0;
        chk("publish_latency", 32'(cycle - last_acc_cycle), 32'd2);
        chk("stale_at_publish", {31'd0, stale}, 32'd0);
        chk("x_dirs_exclusive", {31'd0, x_increment & x_decrement}, 32'd0);
        chk("y_dirs_exclusive", {31'd0, y_increment & y_decrement}, 32'd0);
        if (cont_mode && prev_pub >= 0) chk("publish_period", 32'(cycle - prev_pub), 32'd6);
        prev_pub = cont_mode ? cycle : -1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_publish: out_valid with empty queue (cycle %0d)", cycle);
        end else begin
          exp = exp_q.pop_front();
          chk("dirs", {28'd0, x_increment, x_decrement, y_increment, y_decrement}, {28'd0, exp[19:16]});
          chk("x_threshold", {24'd0, x_threshold}, {24'd0, exp[15:8]});
          chk("y_threshold", {24'd0, y_threshold}, {24'd0, exp[7:0]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, sample_ready}, 32'd0);
    check_neutral("reset");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_release", {31'd0, sample_ready}, 32'd1);

    // x=200 -> inc, y=128 -> neutral.
    window({8'd200, 8'd200, 8'd200, 8'd200}, {8'd128, 8'd128, 8'd128, 8'd128},
           {4'b1000, 8'd200, 8'd128});
    drain();

    // Partial window, then reset mid-window: must be discarded.
    send(8'd250, 8'd10);
    send(8'd250, 8'd10);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ready", {31'd0, sample_ready}, 32'd0);
    check_neutral("midreset");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // 100,110,120,130 -> 115 -> x dec.
    window({8'd100, 8'd110, 8'd120, 8'd130}, {8'd128, 8'd128, 8'd128, 8'd128},
           {4'b0100, 8'd115, 8'd128});
    // x avg 136 on band edge -> neutral; y 60..63 -> 61 -> dec.
    window({8'd136, 8'd136, 8'd136, 8'd136}, {8'd60, 8'd61, 8'd62, 8'd63},
           {4'b0001, 8'd136, 8'd61});
    // x 549/4 -> 137 -> inc; y 120 on lower edge -> neutral.
    window({8'd137, 8'd137, 8'd137, 8'd138}, {8'd120, 8'd120, 8'd120, 8'd120},
           {4'b1000, 8'd137, 8'd120});
    drain();

    // Idle past the watchdog limit.
    repeat (60) @(posedge clk);
    @(negedge clk);
`ifdef TILT_STALE_TIMEOUT_EN
    chk("stale_set", {31'd0, stale}, 32'd1);
    chk("stale_x_increment", {31'd0, x_increment}, 32'd0);
    chk("stale_x_threshold", {24'd0, x_threshold}, 32'd128);
    chk("stale_y_threshold", {24'd0, y_threshold}, 32'd128);
`else
    chk("idle_stale", {31'd0, stale}, 32'd0);
    chk("idle_x_increment", {31'd0, x_increment}, 32'd1);
    chk("idle_x_threshold", {24'd0, x_threshold}, 32'd137);
    chk("idle_y_threshold", {24'd0, y_threshold}, 32'd120);
`endif
    @(posedge clk);
    #1;

    // sample_valid held high across back-to-back windows.
    cont_mode = 1'b1;
    // x 119 -> dec; y 255 -> inc.
    window({8'd119, 8'd119, 8'd119, 8'd119}, {8'd255, 8'd255, 8'd255, 8'd255},
           {4'b0110, 8'd119, 8'd255});
    // x 3/4 -> 0 -> dec; y 547/4 -> 136 -> neutral.
    window({8'd0, 8'd0, 8'd0, 8'd3}, {8'd136, 8'd137, 8'd137, 8'd137},
           {4'b0100, 8'd0, 8'd136});
    window({8'd200, 8'd200, 8'd200, 8'd200}, {8'd128, 8'd128, 8'd128, 8'd128},
           {4'b1000, 8'd200, 8'd128});
    drain();
    cont_mode = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tilt_decoder.md
TILT_DECODER -- requirements
Module: tilt_decoder

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 2, meaning log2 of the samples averaged per axis (range 0..4).
REQ-002 SHALL have parameter DEADBAND, default 8, meaning the neutral half-width around level code 128 (range 0..127).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000000, meaning the cycles without an accepted sample before stale.
REQ-004 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: accel_x  input  8  raw X tilt sample, offset-binary, 128 is level.
REQ-007 SHALL have port: accel_y  input  8  raw Y tilt sample, offset-binary.
REQ-008 SHALL have port: sample_valid  input  1  accel_x/accel_y are valid.
REQ-009 SHALL have port: sample_ready  output  1  block accepts a sample this cycle.
REQ-010 SHALL have ports: x_increment, x_decrement, y_increment, y_decrement  output  1 each  direction commands for the ball mover.
REQ-011 SHALL have ports: x_threshold, y_threshold  output  8 each  averaged tilt code.
REQ-012 SHALL have port: out_valid  output  1  one-cycle pulse when the direction/threshold outputs update.
REQ-013 SHALL have port: stale  output  1  no fresh samples; outputs are neutral.

Function
REQ-014 SHALL accept a sample only on a cycle where sample_valid and sample_ready are both 1.
REQ-015 SHALL use FSM states ACCUM, COMPUTE, PUBLISH; ACCUM is the reset state.
REQ-016 SHALL, in ACCUM, hold sample_ready=1, add each accepted sample into per-axis sums of width 8+AVG_LOG2, and count accepts.
REQ-017 SHALL move ACCUM->COMPUTE on the cycle accepting sample number 2^AVG_LOG2, COMPUTE->PUBLISH after one cycle, and PUBLISH->ACCUM after one cycle.
REQ-018 SHALL hold sample_ready=0 in COMPUTE and PUBLISH; samples offered then are not accepted and are not counted.
REQ-019 SHALL compute avg = sum >> AVG_LOG2, truncating with no rounding, per axis in COMPUTE.
REQ-020 SHALL, per axis, set increment=1 when avg > 128+DEADBAND, decrement=1 when avg < 128-DEADBAND, and both 0 otherwise; both SHALL never be 1 together.
REQ-021 SHALL register threshold=avg and the direction bits at the COMPUTE->PUBLISH edge, so they are visible during PUBLISH.
REQ-022 SHALL assert out_valid exactly during PUBLISH, two cycles after the final sample is accepted.
REQ-023 SHALL hold direction and threshold outputs stable between updates.
REQ-024 SHALL clear the sums and the count when entering ACCUM.

Reset
REQ-025 SHALL, when reset=0, immediately force: state ACCUM, sums and count 0, all increment/decrement 0, thresholds 128, out_valid 0, stale 0, sample_ready 0.
REQ-026 SHALL discard a partial accumulation if reset asserts mid-operation; the first averaging window after release starts empty.
REQ-027 SHALL drive sample_ready=1 from the first clock edge after reset deasserts.

Configuration
REQ-028 SHALL compile the stale watchdog only when macro TILT_STALE_TIMEOUT_EN is defined.
REQ-029 SHALL, with TILT_STALE_TIMEOUT_EN defined, count cycles since the last accepted sample; when the count reaches TIMEOUT_CYCLES it SHALL set stale=1, force direction bits 0 and thresholds 128, clear the sums and the count, and enter ACCUM.
REQ-030 SHALL clear stale at the next PUBLISH.
REQ-031 SHALL reset the watchdog counter on each accept.
REQ-032 SHALL, without TILT_STALE_TIMEOUT_EN, tie stale to 0, omit the watchdog counter, and keep the port list unchanged.

Structure
REQ-033 SHALL put in shared package tilt_pkg: the FSM state enum, TILT_LEVEL=8'd128, and TILT_NEUTRAL_DIR=2'b00.
REQ-034 SHALL instantiate sub-module tilt_axis_filter once per axis; it holds the accumulator, the averager and the dead-band comparator, while the top holds the FSM and the watchdog.

Verification
REQ-035 SHALL verify: assert reset=0 mid-window, then release -> all direction bits 0, thresholds 128, stale 0, and the next window needs a full 4 samples.
REQ-036 SHALL verify: 4 samples x=200, y=128 -> x_increment=1, x_threshold=200, y bits 0, y_threshold=128, out_valid high 2 cycles after the 4th accept.
REQ-037 SHALL verify: x samples 100,110,120,130 -> avg 115 -> x_decrement=1, x_threshold=115.
REQ-038 SHALL verify: with DEADBAND=8, x avg 136 -> both x bits 0; x avg 137 -> x_increment=1.
REQ-039 SHALL verify: sample_valid held high continuously -> exactly 4 accepts per window, sample_ready=0 for 2 cycles, one out_valid per 6 cycles.
REQ-040 SHALL verify: with TILT_STALE_TIMEOUT_EN and TIMEOUT_CYCLES=50, after a publish with x_increment=1 and no samples for 50 cycles -> stale=1, x_increment=0, thresholds 128; without the macro the outputs are unchanged and stale stays 0.
